// File: rtl/lcd_write_scheduler.sv
// Round-robin arbiter between two LCD display lines that writes the granted line's
// snapshotted digits into LCDI as a paced burst of single-character writes.
module lcd_write_scheduler #(
    parameter int NDIG  = 14,
    parameter int DW    = 6,
    parameter int BASE0 = 0,
    parameter int BASE1 = 16,
    parameter int GAP   = 0
) (
    input  logic                 CLK_50MHZ,
    input  logic                 RST,
    input  logic [1:0]           REQ,
    input  logic [NDIG*DW-1:0]   DIGITS0,
    input  logic [NDIG*DW-1:0]   DIGITS1,
    output logic [1:0]           DONE,
    output logic                 BUSY,
    output logic                 LCD_WE,
    output logic [7:0]           LCD_WRITE_ADDR,
    output logic [7:0]           LCD_WRITE_DATA
);

    typedef enum logic [1:0] {IDLE, WRITE, GAPW, FIN} schedState;

    localparam logic [4:0] lastIdx  = 5'(NDIG - 1);
    localparam logic [7:0] gapLoad  = 8'(GAP > 0 ? GAP - 1 : 0);
    localparam logic       gapOn    = (GAP > 0);
    localparam logic [7:0] base0    = 8'(BASE0);
    localparam logic [7:0] base1    = 8'(BASE1);

    schedState          state, stateNext;
    logic [NDIG*DW-1:0] snapshot, snapshotNext;
    logic               sel, selNext;
    logic               last, lastNext;
    logic [4:0]         idx, idxNext;
    logic [7:0]         addrPtr, addrPtrNext;
    logic [7:0]         gapCnt, gapCntNext;
    logic [1:0]         doneNext;
    logic               busyNext;
    logic               weNext;
    logic [7:0]         addrNext;
    logic [7:0]         dataNext;
    logic               grantLine;

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state          <= IDLE;
            snapshot       <= '0;
            sel            <= 1'b0;
            last           <= 1'b1;
            idx            <= '0;
            addrPtr        <= '0;
            gapCnt         <= '0;
            DONE           <= '0;
            BUSY           <= 1'b0;
            LCD_WE         <= 1'b0;
            LCD_WRITE_ADDR <= '0;
            LCD_WRITE_DATA <= '0;
        end else begin
            state          <= stateNext;
            snapshot       <= snapshotNext;
            sel            <= selNext;
            last           <= lastNext;
            idx            <= idxNext;
            addrPtr        <= addrPtrNext;
            gapCnt         <= gapCntNext;
            DONE           <= doneNext;
            BUSY           <= busyNext;
            LCD_WE         <= weNext;
            LCD_WRITE_ADDR <= addrNext;
            LCD_WRITE_DATA <= dataNext;
        end
    end

    always_comb begin
        stateNext    = state;
        snapshotNext = snapshot;
        selNext      = sel;
        lastNext     = last;
        idxNext      = idx;
        addrPtrNext  = addrPtr;
        gapCntNext   = gapCnt;
        doneNext     = '0;
        busyNext     = BUSY;
        weNext       = 1'b0;
        addrNext     = LCD_WRITE_ADDR;
        dataNext     = LCD_WRITE_DATA;
        grantLine    = (REQ == 2'b11) ? ~last : REQ[1];

        case (state)
            IDLE: begin
                if (|REQ) begin
                    selNext      = grantLine;
                    snapshotNext = grantLine ? DIGITS1 : DIGITS0;
                    addrPtrNext  = grantLine ? base1 : base0;
                    idxNext      = '0;
                    busyNext     = 1'b1;
                    stateNext    = WRITE;
                end
            end
            WRITE: begin
                // Snapshot shifts left each write so the next character is always the top field.
                weNext       = 1'b1;
                addrNext     = addrPtr;
                dataNext     = 8'(snapshot[NDIG*DW-1 -: DW]);
                snapshotNext = snapshot << DW;
                addrPtrNext  = addrPtr + 8'd1;
                idxNext      = idx + 5'd1;
                if (idx == lastIdx) begin
                    stateNext = FIN;
                end else if (gapOn) begin
                    stateNext  = GAPW;
                    gapCntNext = gapLoad;
                end
            end
            GAPW: begin
                if (gapCnt == 8'd0) begin
                    stateNext = WRITE;
                end else begin
                    gapCntNext = gapCnt - 8'd1;
                end
            end
            FIN: begin
                // FIN spans two edges; DONE being high marks the second one.
                if (DONE == 2'b00) begin
                    doneNext = sel ? 2'b10 : 2'b01;
                end else begin
                    busyNext  = 1'b0;
                    lastNext  = sel;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed-plus-random bench for lcd_write_scheduler; two instances cover the
// default configuration and a GAP=2 / wrapping-address configuration.
module tb_lcd_write_scheduler;

    localparam int NDIG = 14;
    localparam int DW   = 6;
    localparam int W    = NDIG * DW;

    logic         simClock;
    logic         rst;
    logic [1:0]   reqA, reqB;
    logic [W-1:0] digA0, digA1, digB0, digB1;
    logic [1:0]   doneA, doneB;
    logic         busyA, busyB, weA, weB;
    logic [7:0]   addrA, addrB, dataA, dataB;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int lastLine[2];
    int prevAddr[2];
    int prevData[2];

    lcd_write_scheduler #(.NDIG(NDIG), .DW(DW), .BASE0(0), .BASE1(16), .GAP(0)) dutA (
        .CLK_50MHZ(simClock), .RST(rst), .REQ(reqA), .DIGITS0(digA0), .DIGITS1(digA1),
        .DONE(doneA), .BUSY(busyA), .LCD_WE(weA), .LCD_WRITE_ADDR(addrA), .LCD_WRITE_DATA(dataA)
    );

    lcd_write_scheduler #(.NDIG(NDIG), .DW(DW), .BASE0(0), .BASE1(250), .GAP(2)) dutB (
        .CLK_50MHZ(simClock), .RST(rst), .REQ(reqB), .DIGITS0(digB0), .DIGITS1(digB1),
        .DONE(doneB), .BUSY(busyB), .LCD_WE(weB), .LCD_WRITE_ADDR(addrB), .LCD_WRITE_DATA(dataB)
    );

    initial begin
        simClock = 1'b0;
        forever #5 simClock = ~simClock;
    end

    function automatic int gapOf(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int baseOf(input int d, input int line);
        if (line == 0) return 0;
        return (d == 0) ? 16 : 250;
    endfunction

    function automatic int charOf(input logic [W-1:0] s, input int k);
        logic [W-1:0] t;
        t = s >> ((NDIG - 1 - k) * DW);
        return int'(t[DW-1:0]);
    endfunction

    function automatic logic [W-1:0] rndDigits();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < NDIG; k++) v = (v << DW) | W'($urandom_range(0, 63));
        return v;
    endfunction

    function automatic logic [1:0] getReq(input int d);
        return (d == 0) ? reqA : reqB;
    endfunction

    function automatic logic [W-1:0] getDig(input int d, input int line);
        if (d == 0) return (line == 0) ? digA0 : digA1;
        return (line == 0) ? digB0 : digB1;
    endfunction

    task automatic setReq(input int d, input logic [1:0] v);
        if (d == 0) reqA = v;
        else        reqB = v;
    endtask

    task automatic setDig(input int d, input int line, input logic [W-1:0] v);
        if (d == 0 && line == 0) digA0 = v;
        else if (d == 0)         digA1 = v;
        else if (line == 0)      digB0 = v;
        else                     digB1 = v;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input int d, input int eDone, input int eBusy, input int eWe,
                            input int eAddr, input int eData);
        string p;
        p = (d == 0) ? "A" : "B";
        check({p, ".done"}, int'((d == 0) ? doneA : doneB), eDone);
        check({p, ".busy"}, int'((d == 0) ? busyA : busyB), eBusy);
        check({p, ".we"},   int'((d == 0) ? weA   : weB),   eWe);
        check({p, ".addr"}, int'((d == 0) ? addrA : addrB), eAddr);
        check({p, ".data"}, int'((d == 0) ? dataA : dataB), eData);
    endtask

    // Called at the falling edge of the IDLE cycle in which REQ is sampled.
    task automatic watchBurst(input int d, input int line, input bit scramble, input int abortAt);
        logic [W-1:0] snap;
        int g, base, lastRel, cnt, eWe, eAddr, eData, eDone;
        snap    = getDig(d, line);
        g       = gapOf(d);
        base    = baseOf(d, line);
        lastRel = 2 + (NDIG - 1) * (g + 1);
        for (int n = 1; n <= lastRel + 1; n++) begin
            @(negedge simClock);
            if (scramble && n == 1) setDig(d, line, '1);
            cnt = 0;
            if (n >= 2) cnt = ((n - 2) / (g + 1) + 1 < NDIG) ? (n - 2) / (g + 1) + 1 : NDIG;
            eWe = (n >= 2 && (n - 2) % (g + 1) == 0 && (n - 2) / (g + 1) < NDIG) ? 1 : 0;
            eAddr = (cnt > 0) ? (base + cnt - 1) % 256 : prevAddr[d];
            eData = (cnt > 0) ? charOf(snap, cnt - 1) : prevData[d];
            eDone = (n == lastRel + 1) ? (1 << line) : 0;
            checkAll(d, eDone, 1, eWe, eAddr, eData);
            if (n == abortAt) begin
                rst = 1'b1;
                return;
            end
            if (n == lastRel + 1) setReq(d, getReq(d) & ~(2'b01 << line));
        end
        prevAddr[d] = (base + NDIG - 1) % 256;
        prevData[d] = charOf(snap, NDIG - 1);
        lastLine[d] = line;
    endtask

    task automatic serveAll(input int d, input bit scramble);
        logic [1:0] r;
        int line;
        for (int it = 0; it < 4 && getReq(d) != 2'b00; it++) begin
            r = getReq(d);
            if (r == 2'b11) line = (lastLine[d] == 1) ? 0 : 1;
            else            line = r[1] ? 1 : 0;
            watchBurst(d, line, scramble, 0);
            @(negedge simClock);
            checkAll(d, 0, 0, 0, prevAddr[d], prevData[d]);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            lastLine[d] = 1;
            prevAddr[d] = 0;
            prevData[d] = 0;
        end
    endtask

    initial begin
        logic [W-1:0] asc;
        rst  = 1'b1;
        reqA = 2'b00;
        reqB = 2'b00;
        digA0 = rndDigits(); digA1 = rndDigits();
        digB0 = rndDigits(); digB1 = rndDigits();
        modelReset();

        repeat (3) @(negedge simClock);
        checkAll(0, 0, 0, 0, 0, 0);
        checkAll(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge simClock);
            checkAll(0, 0, 0, 0, 0, 0);
            checkAll(1, 0, 0, 0, 0, 0);
        end

        // Contention from reset: line 0 then line 1, then again line 0 first.
        setReq(0, 2'b11);
        serveAll(0, 1'b0);
        digA0 = rndDigits(); digA1 = rndDigits();
        setReq(0, 2'b11);
        serveAll(0, 1'b0);

        // Single request with ascending characters 1..14.
        asc = '0;
        for (int k = 1; k <= NDIG; k++) asc = (asc << DW) | W'(k);
        digA0 = asc;
        setReq(0, 2'b01);
        serveAll(0, 1'b0);

        // GAP=2 with live digits overwritten after grant.
        digB0 = rndDigits();
        setReq(1, 2'b01);
        serveAll(1, 1'b1);

        // Line 1 at base 250 wraps past 255.
        digB1 = rndDigits();
        setReq(1, 2'b10);
        serveAll(1, 1'b0);

        // Reset during the 5th write of line 1, then restart with REQ held.
        digA1 = rndDigits();
        setReq(0, 2'b10);
        watchBurst(0, 1, 1'b0, 6);
        @(negedge simClock);
        modelReset();
        checkAll(0, 0, 0, 0, 0, 0);
        checkAll(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        serveAll(0, 1'b0);

        // Randomized request patterns on both instances.
        for (int i = 0; i < 6; i++) begin
            int d;
            d = i % 2;
            setDig(d, 0, rndDigits());
            setDig(d, 1, rndDigits());
            setReq(d, 2'($urandom_range(1, 3)));
            serveAll(d, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge simClock);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
